// File: rtl/tetris_pkg.sv
// Shared game-core definitions: piece-fall FSM states and playfield defaults,
// used by the fall controller, the board and the drop-speed generator.
package tetris_pkg;

  // Default playfield height in rows; row 0 is the top.
  localparam int BOARD_H_DEF    = 20;
  // Default row-index width; 2^Y_W must exceed the board height.
  localparam int Y_W_DEF        = 5;
  // Default number of blocked fall ticks absorbed before a lock.
  localparam int LOCK_TICKS_DEF = 1;

  // Piece-fall controller states.
  typedef enum logic [2:0] {
    IDLE,
    SPAWN_CHK,
    FALL_WAIT,
    DROP_CHK,
    LOCK,
    LOCK_WAIT,
    OVER
  } fall_state_t;

  // Width of a counter that must reach lock_ticks; never narrower than 1 bit.
  function automatic int rest_cnt_w(input int lock_ticks);
    return (lock_ticks < 1) ? 1 : $clog2(lock_ticks + 1);
  endfunction

endpackage

// File: rtl/piece_fall_ctrl.sv
// Gravity and lock controller for the active piece. Turns fall ticks into
// collision-checked one-row descents, locks a resting piece after a grace of
// LOCK_TICKS blocked ticks, waits for the board merge, then spawns the next
// piece and reports game-over when the spawn position is already occupied.
module piece_fall_ctrl
  import tetris_pkg::*;
#(
  parameter int BOARD_H    = BOARD_H_DEF,
  parameter int Y_W        = Y_W_DEF,
  parameter int LOCK_TICKS = LOCK_TICKS_DEF
) (
  input  logic           i_pixclk,
  input  logic           i_reset_n,
  input  logic           i_fall_tick,
  input  logic           i_start,
  output logic           o_chk_req,
  output logic [Y_W-1:0] o_chk_y,
  input  logic           i_chk_ack,
  input  logic           i_chk_hit,
  output logic [Y_W-1:0] o_piece_y,
  output logic           o_active,
  output logic           o_spawn,
  output logic           o_lock,
  input  logic           i_lock_done,
  output logic           o_game_over
);

  localparam int RW = rest_cnt_w(LOCK_TICKS);
  localparam logic [Y_W-1:0] FLOOR_Y  = Y_W'(BOARD_H - 1);
  localparam logic [RW-1:0]  LOCK_MAX = RW'(LOCK_TICKS);

  fall_state_t    state_reg, state_next;
  logic [Y_W-1:0] piece_y_reg, piece_y_next;
  logic [Y_W-1:0] chk_y_reg, chk_y_next;
  logic [RW-1:0]  rest_reg, rest_next;
  logic           chk_req_reg, chk_req_next;
  logic           spawn_reg, spawn_next;
  logic           lock_reg, lock_next;
  logic           active_reg, active_next;
  logic           game_over_reg, game_over_next;
  logic           ack_ok;
  logic           grace_spent;

  // An ack only counts while a request is actually outstanding.
  assign ack_ok      = i_chk_ack && chk_req_reg;
  assign grace_spent = (rest_reg == LOCK_MAX);

  // State register and all registered outputs; async reset drops any request.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= IDLE;
      piece_y_reg   <= '0;
      chk_y_reg     <= '0;
      rest_reg      <= '0;
      chk_req_reg   <= 1'b0;
      spawn_reg     <= 1'b0;
      lock_reg      <= 1'b0;
      active_reg    <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      piece_y_reg   <= piece_y_next;
      chk_y_reg     <= chk_y_next;
      rest_reg      <= rest_next;
      chk_req_reg   <= chk_req_next;
      spawn_reg     <= spawn_next;
      lock_reg      <= lock_next;
      active_reg    <= active_next;
      game_over_reg <= game_over_next;
    end
  end

  // Next-state and next-output logic; everything defaults to hold or idle.
  always_comb begin
    state_next   = state_reg;
    piece_y_next = piece_y_reg;
    chk_y_next   = chk_y_reg;
    rest_next    = rest_reg;
    chk_req_next = chk_req_reg;
    spawn_next   = 1'b0;
    lock_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = SPAWN_CHK;
        end
      end

      // The spawn request is raised one cycle after entering, at row 0.
      SPAWN_CHK: begin
        if (ack_ok) begin
          chk_req_next = 1'b0;
          if (i_chk_hit) begin
            state_next = OVER;
          end else begin
            piece_y_next = '0;
            rest_next    = '0;
            spawn_next   = 1'b1;
            state_next   = FALL_WAIT;
          end
        end else if (!chk_req_reg) begin
          chk_req_next = 1'b1;
          chk_y_next   = '0;
        end
      end

      // A tick on the bottom row is a blocked tick with no board query;
      // otherwise the request goes out together with the state change.
      FALL_WAIT: begin
        if (i_fall_tick) begin
          if (piece_y_reg == FLOOR_Y) begin
            if (grace_spent) begin
              state_next = LOCK;
            end else begin
              rest_next = rest_reg + RW'(1);
            end
          end else begin
            state_next   = DROP_CHK;
            chk_req_next = 1'b1;
            chk_y_next   = piece_y_reg + Y_W'(1);
          end
        end
      end

      // chk_y_reg holds piece_y+1 for the whole handshake, so it is the
      // committed row when the check comes back clear.
      DROP_CHK: begin
        if (ack_ok) begin
          chk_req_next = 1'b0;
          if (!i_chk_hit) begin
            piece_y_next = chk_y_reg;
            rest_next    = '0;
            state_next   = FALL_WAIT;
          end else if (grace_spent) begin
            state_next = LOCK;
          end else begin
            rest_next  = rest_reg + RW'(1);
            state_next = FALL_WAIT;
          end
        end
      end

      LOCK: begin
        lock_next  = 1'b1;
        state_next = LOCK_WAIT;
      end

      LOCK_WAIT: begin
        if (i_lock_done) begin
          state_next = SPAWN_CHK;
        end
      end

      OVER: begin
        if (i_start) begin
          state_next = SPAWN_CHK;
        end
      end

      default: begin
        state_next   = IDLE;
        chk_req_next = 1'b0;
      end
    endcase
  end

  // Status levels are registered from the state being entered.
  always_comb begin
    active_next    = (state_next == FALL_WAIT) || (state_next == DROP_CHK);
    game_over_next = (state_next == OVER);
  end

  assign o_chk_req   = chk_req_reg;
  assign o_chk_y     = chk_y_reg;
  assign o_piece_y   = piece_y_reg;
  assign o_active    = active_reg;
  assign o_spawn     = spawn_reg;
  assign o_lock      = lock_reg;
  assign o_game_over = game_over_reg;

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// Directed bench for piece_fall_ctrl: spawn, descent, floor lock, blocked
// lock, game-over/restart and reset in the middle of a handshake.
module tb_piece_fall_ctrl;

  logic       pixclk    = 1'b0;
  logic       reset_n   = 1'b0;
  logic       fall_tick = 1'b0;
  logic       start     = 1'b0;
  logic       chk_ack   = 1'b0;
  logic       chk_hit   = 1'b0;
  logic       lock_done = 1'b0;
  logic       chk_req;
  logic [4:0] chk_y;
  logic [4:0] piece_y;
  logic       active;
  logic       spawn;
  logic       lock;
  logic       game_over;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 pixclk = ~pixclk;

  piece_fall_ctrl #(
    .BOARD_H    (20),
    .Y_W        (5),
    .LOCK_TICKS (1)
  ) dut (
    .i_pixclk    (pixclk),
    .i_reset_n   (reset_n),
    .i_fall_tick (fall_tick),
    .i_start     (start),
    .o_chk_req   (chk_req),
    .o_chk_y     (chk_y),
    .i_chk_ack   (chk_ack),
    .i_chk_hit   (chk_hit),
    .o_piece_y   (piece_y),
    .o_active    (active),
    .o_spawn     (spawn),
    .o_lock      (lock),
    .i_lock_done (lock_done),
    .o_game_over (game_over)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge pixclk);
    #1;
  endtask

  // One descent: tick, hold the request wait_cyc cycles, then a clear ack.
  task automatic drop_ok(input int exp_y, input int wait_cyc, input bit tick_during_wait);
    fall_tick = 1'b1;
    step();
    fall_tick = 1'b0;
    check("drop_req", chk_req, 1);
    check("drop_chk_y", chk_y, exp_y);
    fall_tick = tick_during_wait;
    for (int w = 0; w < wait_cyc; w++) step();
    fall_tick = 1'b0;
    chk_ack = 1'b1;
    chk_hit = 1'b0;
    step();
    chk_ack = 1'b0;
    check("drop_y", piece_y, exp_y);
    check("drop_req_low", chk_req, 0);
  endtask

  // Spawn handshake: request appears two cycles after the trigger pulse.
  task automatic spawn_ack(input bit hit);
    check("spawn_req_late", chk_req, 0);
    step();
    check("spawn_req", chk_req, 1);
    check("spawn_chk_y", chk_y, 0);
    chk_ack = 1'b1;
    chk_hit = hit;
    step();
    chk_ack = 1'b0;
    chk_hit = 1'b0;
    check("spawn_req_low", chk_req, 0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_req", chk_req, 0);
    check("rst_chk_y", chk_y, 0);
    check("rst_piece_y", piece_y, 0);
    check("rst_active", active, 0);
    check("rst_over", game_over, 0);
    reset_n = 1'b1;
    step();

    // First spawn
    start = 1'b1;
    step();
    start = 1'b0;
    spawn_ack(1'b0);
    check("spawn_pulse", spawn, 1);
    check("spawn_y", piece_y, 0);
    check("spawn_active", active, 1);
    step();
    check("spawn_pulse_end", spawn, 0);

    // Five descents, acked on the third request cycle; ticks held during
    // the third handshake must not add a row or queue a new check
    for (int i = 1; i <= 5; i++) begin
      drop_ok(i, 2, (i == 3));
      if (i == 3) begin
        step();
        check("tick_dropped_req", chk_req, 0);
        check("tick_dropped_y", piece_y, 3);
      end
    end
    check("five_rows", piece_y, 5);

    // Descend to the floor row
    for (int i = 6; i <= 19; i++) drop_ok(i, 0, 1'b0);
    check("at_floor", piece_y, 19);

    // Floor: first tick absorbed with no request, second locks at n+2
    fall_tick = 1'b1;
    step();
    fall_tick = 1'b0;
    check("floor_noreq", chk_req, 0);
    check("floor_active", active, 1);
    fall_tick = 1'b1;
    step();
    fall_tick = 1'b0;
    check("floor_lock_n1", lock, 0);
    step();
    check("floor_lock_n2", lock, 1);
    check("floor_lock_inactive", active, 0);
    step();
    check("floor_lock_end", lock, 0);
    lock_done = 1'b1;
    step();
    lock_done = 1'b0;
    spawn_ack(1'b0);
    check("respawn_pulse", spawn, 1);
    check("respawn_y", piece_y, 0);

    // Collision-blocked ticks: first one rests, second one locks
    for (int b = 0; b < 2; b++) begin
      fall_tick = 1'b1;
      step();
      fall_tick = 1'b0;
      check("blk_chk_y", chk_y, 1);
      chk_ack = 1'b1;
      chk_hit = 1'b1;
      step();
      chk_ack = 1'b0;
      chk_hit = 1'b0;
      check("blk_y_held", piece_y, 0);
      check("blk_req_low", chk_req, 0);
    end
    check("blk_lock_n1", lock, 0);
    step();
    check("blk_lock_n2", lock, 1);
    lock_done = 1'b1;
    step();
    lock_done = 1'b0;

    // Spawn collides -> game over
    spawn_ack(1'b1);
    check("over_flag", game_over, 1);
    check("over_inactive", active, 0);
    check("over_no_spawn", spawn, 0);
    step();
    check("over_y_held", piece_y, 0);

    // Restart from OVER
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_over_clr", game_over, 0);
    spawn_ack(1'b0);
    check("restart_spawn", spawn, 1);
    drop_ok(1, 0, 1'b0);

    // Reset while a drop request is outstanding
    fall_tick = 1'b1;
    step();
    fall_tick = 1'b0;
    check("pre_rst_req", chk_req, 1);
    check("pre_rst_chk_y", chk_y, 2);
    reset_n = 1'b0;
    #1;
    check("midrst_req", chk_req, 0);
    check("midrst_chk_y", chk_y, 0);
    check("midrst_piece_y", piece_y, 0);
    check("midrst_active", active, 0);
    step();
    reset_n = 1'b1;
    chk_ack = 1'b1;
    step();
    chk_ack = 1'b0;
    check("late_ack_spawn", spawn, 0);
    check("late_ack_active", active, 0);
    check("late_ack_req", chk_req, 0);
    step();
    check("idle_req", chk_req, 0);
    check("idle_over", game_over, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
